// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU among NREQ requesters with round-robin
// arbitration, and owns the ALU opcode/ibus pins.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req             per-requester request level, held until done
//   req_op          per-requester opcode, slice i = [4i+3:4i]
//   req_a, req_b    per-requester operands, slice i = [WIDTH*i +: WIDTH]
//   gnt             one-hot grant, high from grant through the done cycle
//   done            one-hot, one-cycle completion pulse
//   err             pulses with done for a rejected or timed-out transaction
//   result          ALU result, valid with done, held until the next done
//   busy            high whenever the sequencer is not idle
//   alu_opcode      ALU opcode (NOP = 0000 when idle)
//   alu_ibus        ALU input bus: A for two cycles, then B until fin
//   alu_obus        ALU output bus, captured on fin
//   alu_fin         ALU completion strobe
module alu_req_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [4*NREQ-1:0]       req_op,
    input  logic [WIDTH*NREQ-1:0]   req_a,
    input  logic [WIDTH*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic [WIDTH-1:0]        result,
    output logic                    busy,
    output logic [3:0]              alu_opcode,
    output logic [WIDTH-1:0]        alu_ibus,
    input  logic [WIDTH-1:0]        alu_obus,
    input  logic                    alu_fin
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_MIN = 4'b0011;   // ADD
    localparam logic [3:0] OP_MAX = 4'b1011;   // DIV

    typedef enum logic [1:0] {IDLE, OP_A, OP_B, GAP} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              rej_q, rej_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [3:0]        opc_q, opc_d;
    logic [WIDTH-1:0]  ibus_q, ibus_d;

    logic              found;
    logic [IW-1:0]     pick;
    logic [3:0]        pick_op;

    // Round-robin search: first requester strictly after the pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign pick_op = req_op[4*int'(pick) +: 4];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rej_d    = rej_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    ptr_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    op_d        = pick_op;
                    a_d         = req_a[WIDTH*int'(pick) +: WIDTH];
                    b_d         = req_b[WIDTH*int'(pick) +: WIDTH];
                    // An invalid op still passes through OP_A so done lands
                    // one edge after the grant, but the ALU pins stay at NOP.
                    rej_d       = (pick_op < OP_MIN) || (pick_op > OP_MAX);
                    cnt_d       = '0;
                    state_d     = OP_A;
                end
            end
            OP_A, OP_B: begin
                cnt_d = cnt_q + 1'b1;
                if (rej_q) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    state_d = GAP;
                end else if (alu_fin) begin
                    // fin wins over a coincident timeout
                    result_d = alu_obus;
                    done_d   = gnt_q;
                    state_d  = GAP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    done_d   = gnt_q;
                    err_d    = 1'b1;
                    state_d  = GAP;
                end else if (state_q == OP_A && cnt_q == CW'(1)) begin
                    state_d = OP_B;
                end
            end
            GAP: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // ALU pins are registered from next-state values so there is no
        // combinational path from req_* to the ALU.
        opc_d  = OP_NOP;
        ibus_d = '0;
        if (state_d == OP_A && !rej_d) begin
            opc_d  = op_d;
            ibus_d = a_d;
        end else if (state_d == OP_B) begin
            opc_d  = op_d;
            ibus_d = b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(NREQ - 1);
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            rej_q    <= 1'b0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            opc_q    <= OP_NOP;
            ibus_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rej_q    <= rej_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            opc_q    <= opc_d;
            ibus_q   <= ibus_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign result     = result_q;
    assign busy       = (state_q != IDLE);
    assign alu_opcode = opc_q;
    assign alu_ibus   = ibus_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboarded bench for alu_req_arbiter with a behavioural ALU that
// asserts fin a programmable number of cycles after the opcode appears.
module tb_alu_req_arbiter;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam logic [3:0] ADD = 4'b0011, MUL = 4'b1010, DIV = 4'b1011, RD1 = 4'b0001;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [4*N-1:0] req_op = '0;
    logic [W*N-1:0] req_a = '0, req_b = '0;
    logic [N-1:0]   gnt, done;
    logic           err, busy;
    logic [W-1:0]   result, alu_ibus;
    logic [3:0]     alu_opcode;
    logic [W-1:0]   alu_obus = '0;
    logic           alu_fin = 1'b0;

    alu_req_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
        .alu_opcode(alu_opcode), .alu_ibus(alu_ibus), .alu_obus(alu_obus), .alu_fin(alu_fin)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    typedef struct {
        logic [N-1:0] dn;
        logic         e;
        logic [W-1:0] res;
    } exp_t;
    exp_t q[$];

    logic [3:0]   top [N];
    logic [W-1:0] ta  [N];
    logic [W-1:0] tbv [N];
    int fin_lat = 3;
    int k = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            ADD:     return a + b;
            MUL:     return a * b;
            DIV:     return (b != 0) ? a / b : '0;
            default: return '0;
        endcase
    endfunction

    // Behavioural ALU: checks operand sequencing and raises fin at cycle fin_lat.
    always @(negedge clk) begin
        int g;
        alu_fin = 1'b0;
        if (rst || alu_opcode == 4'b0000) begin
            k = 0;
        end else begin
            g = -1;
            for (int i = 0; i < N; i++) if (gnt[i]) g = i;
            chk("opcode_valid", (alu_opcode >= ADD && alu_opcode <= DIV), 1);
            chk("gnt_during_op", (g >= 0), 1);
            if (g >= 0) begin
                chk("alu_opcode", alu_opcode, top[g]);
                chk("alu_ibus", alu_ibus, (k < 2) ? ta[g] : tbv[g]);
                if (k == fin_lat) begin
                    alu_fin  = 1'b1;
                    alu_obus = alu_f(top[g], ta[g], tbv[g]);
                end
            end
            k++;
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t x;
        if (!rst) begin
            chk("gnt_onehot", ($countones(gnt) <= 1), 1);
            if (done != '0) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=%b with empty scoreboard", done);
                end else begin
                    x = q.pop_front();
                    chk("done", done, x.dn);
                    chk("err", err, x.e);
                    chk("result", result, x.res);
                    chk("gap_opcode", alu_opcode, 4'b0000);
                    chk("gap_ibus", alu_ibus, 0);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        top[i] = op; ta[i] = a; tbv[i] = b;
        req_op[4*i +: 4] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    task automatic expect_done(input int i, input logic e, input logic [W-1:0] r);
        exp_t x;
        x.dn = '0; x.dn[i] = 1'b1; x.e = e; x.res = r;
        q.push_back(x);
    endtask

    task automatic wait_done(input int i, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!done[i] && n < 60);
        if (!done[i]) chk("wait_done_timeout", done, 1 << i);
        req[i] = 1'b0;
    endtask

    task automatic wait_gnt(input int i);
        int n = 0;
        do begin @(negedge clk); n++; end while (!gnt[i] && n < 60);
        if (!gnt[i]) chk("wait_gnt_timeout", gnt, 1 << i);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) set_req(i, ADD, 0, 0);
        set_req(0, ADD, 32'hFFFFFF9B, 32'h0000003F);
        fin_lat = 3;
        req = 4'b1111;

        // Reset held with all requests pending
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_done", done, 0);
            chk("rst_opcode", alu_opcode, 0);
            chk("rst_busy", busy, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_gnt", gnt, 4'b0001);
        chk("first_busy", busy, 1);
        req = 4'b0001;

        // Single ADD: -101 + 63 = -38
        expect_done(0, 0, 32'hFFFFFFDA);
        wait_done(0, n);

        // Round-robin: 1 and 2 together, then 3 beats re-raised 1
        set_req(1, ADD, 5, 7);
        set_req(2, MUL, 6, 7);
        fin_lat = 4;
        expect_done(1, 0, 32'h0000000C);
        expect_done(2, 0, 32'h0000002A);
        req[1] = 1'b1; req[2] = 1'b1;
        wait_done(1, n);
        wait_gnt(2);
        set_req(3, ADD, 100, 23);
        set_req(1, MUL, 3, 9);
        expect_done(3, 0, 32'h0000007B);
        expect_done(1, 0, 32'h0000001B);
        req[3] = 1'b1; req[1] = 1'b1;
        wait_done(2, n);
        wait_done(3, n);
        wait_done(1, n);

        // Invalid op: rejected without touching the ALU, result holds
        @(negedge clk);
        set_req(1, RD1, 11, 22);
        expect_done(1, 1, 32'h0000001B);
        req[1] = 1'b1;
        @(negedge clk);
        chk("inv_gnt", gnt, 4'b0010);
        chk("inv_done_early", done, 0);
        chk("inv_opcode1", alu_opcode, 0);
        @(negedge clk);
        chk("inv_done", done, 4'b0010);
        chk("inv_err", err, 1);
        chk("inv_opcode2", alu_opcode, 0);
        req[1] = 1'b0;

        // Timeout: fin never comes, 8 cycles in OP_A/OP_B
        fin_lat = -1;
        set_req(0, ADD, 1, 2);
        expect_done(0, 1, 0);
        req[0] = 1'b1;
        wait_done(0, n);
        chk("timeout_latency", n, 10);

        // Next request served normally
        fin_lat = 3;
        set_req(2, ADD, 10, 20);
        expect_done(2, 0, 32'h0000001E);
        req[2] = 1'b1;
        wait_done(2, n);

        // fin coincident with the timeout edge wins
        fin_lat = TO - 1;
        set_req(3, DIV, 100, 7);
        expect_done(3, 0, 32'h0000000E);
        req[3] = 1'b1;
        wait_done(3, n);
        chk("fin_at_timeout_latency", n, 10);

        // Reset during OP_B of a long DIV
        fin_lat = 20;
        set_req(0, DIV, 50, 5);
        req[0] = 1'b1;
        wait_gnt(0);
        repeat (3) @(negedge clk);
        chk("pre_rst_opcode", alu_opcode, DIV);
        chk("pre_rst_ibus_b", alu_ibus, 5);
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_opcode", alu_opcode, 0);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;

        fin_lat = 3;
        set_req(0, ADD, 2, 3);
        expect_done(0, 0, 32'h00000005);
        req[0] = 1'b1;
        wait_done(0, n);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
